mp_pio_bank: RTL and testbench
==============================

# mp_pio_bank

Parametrised multi-channel Avalon-MM parallel I/O bank for the multiprocessor system. It replaces the separate fixed 8-bit PIO instances with a single slave. The bank provides CHANNELS ports of WIDTH bits each, with:
- per-bit direction control;
- atomic set/clear of outputs;
- synchronised inputs with rising-edge capture;
- a masked, level-sensitive interrupt to the Nios II cores.

## Interface
Parameters:
- CHANNELS, 3, number of independent PIO channels (1..16)
- WIDTH, 8, bits per channel (1..32)
- AW, $clog2(CHANNELS)+3, address width (derived; do not override)

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- avs_address  in  AW  {channel[AW-1:3], reg[2:0]}
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data; bits above WIDTH ignored
- avs_readdata  out  32  read data, zero-extended above WIDTH
- avs_readdatavalid  out  1  one-cycle pulse qualifying avs_readdata
- pio_in  in  CHANNELS*WIDTH  pad inputs; channel c occupies [c*WIDTH +: WIDTH]
- pio_out  out  CHANNELS*WIDTH  output register
- pio_oe  out  CHANNELS*WIDTH  output enable (1 = drive); top level builds the tristate
- irq  out  1  interrupt request, registered

## Operation
Registers per channel, selected by reg:
- 0 DATA: read returns the synchronised pin value for bits with oe=0 and pio_out for bits with oe=1. Write loads pio_out.
- 1 DIRECTION: read/write pio_oe.
- 2 IRQMASK: read/write the interrupt mask.
- 3 EDGECAPTURE: read returns the capture bits. Writing 1 to a bit clears it; writing 0 has no effect.
- 4 OUTSET: write ORs the data into pio_out. Reads 0.
- 5 OUTCLEAR: write clears pio_out bits that are 1 in the data. Reads 0.
- 6, 7: reserved. Read 0; writes ignored.

Address and input handling:
- A channel index ≥ CHANNELS reads 0 and ignores writes.
- Each pio_in bit passes a 2-flop synchroniser (s1, s2), then a history flop s3.
- A rising edge is defined as s2 & ~s3 on a bit with oe=0. A detected edge sets the matching EDGECAPTURE bit. Bits with oe=1 never capture.

Edge detection after reset:
- A priming counter suppresses edge detection for the first 3 cycles after reset deasserts.
- This prevents spurious capture from pins that are already high.

Interrupt:
- irq is registered: irq <= OR over all channels of (EDGECAPTURE & IRQMASK).

Collisions:
- If an edge and a write-1-clear hit the same EDGECAPTURE bit in the same cycle, set wins.
- If avs_read and avs_write are asserted together, the write is performed and the read returns the pre-write value.

Reset (reset_reset=1 at a clock edge):
- pio_out, pio_oe, IRQMASK, EDGECAPTURE, s1/s2/s3: all 0.
- avs_readdata = 0, avs_readdatavalid = 0, irq = 0, priming counter = 0.
- Reset asserted mid-read drops the pending readdatavalid.

## Timing
- Write: takes effect at the clock edge where avs_write=1. pio_out/pio_oe change on that edge, so there is 0 wait states.
- Read: avs_readdata is registered, and avs_readdatavalid pulses for exactly one cycle, the cycle after avs_read. Back-to-back reads are allowed every cycle.
- Input path: a pin change that is set up before edge k
  - is in s2 after edge k+1;
  - sets EDGECAPTURE after edge k+2;
  - raises irq after edge k+3, if the bit is masked in.
- DATA read of an input: reflects the s2 value. Pin-to-readdata latency is 3 cycles.
- irq deasserts one cycle after the last qualifying EDGECAPTURE bit is cleared or masked out.

## Configuration
- MP_PIO_BANK_IRQ_EN defined:
  - EDGECAPTURE, IRQMASK, the priming counter and irq are implemented as described above.
- Not defined:
  - EDGECAPTURE and IRQMASK read 0, and writes to them are ignored.
  - irq is tied to 0.
  - The s3 flop and the priming counter are not instantiated.
  - DATA, DIRECTION, OUTSET and OUTCLEAR behave identically in both configurations.

## Test plan
- Reset with pio_in all ones, release → pio_out=0, pio_oe=0, irq=0. EDGECAPTURE reads 0 for 10 cycles.
- CHANNELS=3, WIDTH=8: write DIRECTION ch1=0xFF, DATA ch1=0x0F, OUTSET 0xC0, OUTCLEAR 0x03 → DATA ch1 reads 0xCC. pio_out[15:8]=0xCC. Channels 0 and 2 are unchanged.
- Ch0 oe=0, IRQMASK=0x01; pulse pio_in[0] 0→1 → EDGECAPTURE ch0 reads 0x01 at edge k+2, irq=1 at edge k+3. Write 0x01 to EDGECAPTURE → irq=0 one cycle later.
- Write-1-clear of EDGECAPTURE bit 2 in the same cycle that a new edge arrives on bit 2 → bit 2 remains 1.
- Read address with channel=3 (nonexistent) and reg 6 of ch0 → readdata 0x00000000, readdatavalid one cycle after each read. A write to either address leaves all state unchanged.
- Build without MP_PIO_BANK_IRQ_EN; toggle inputs with IRQMASK written 0xFF → irq stays 0. EDGECAPTURE and IRQMASK read 0.

Source files
------------

// File: rtl/mp_pio_bank.sv
// mp_pio_bank: multi-channel Avalon-MM parallel I/O bank.
//
// Each channel has WIDTH bits. It provides per-bit direction, atomic
// set/clear of outputs and synchronised inputs. It also has rising-edge
// capture with a masked, level-sensitive interrupt.
//
// Build option: define MP_PIO_BANK_IRQ_EN to implement EDGECAPTURE, IRQMASK,
// the post-reset priming counter and irq. When the macro is left undefined:
// - those registers read 0 and ignore writes;
// - irq is tied low;
// - the history flop and the priming counter are not built.
//
// Address map: {channel, reg[2:0]}. The registers are:
// 0 DATA, 1 DIRECTION, 2 IRQMASK, 3 EDGECAPTURE, 4 OUTSET, 5 OUTCLEAR.
// Registers 6 and 7 are reserved.

module mp_pio_bank #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int AW       = $clog2(CHANNELS) + 3
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [AW-1:0]             avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  output logic                      avs_readdatavalid,
  input  logic [CHANNELS*WIDTH-1:0] pio_in,
  output logic [CHANNELS*WIDTH-1:0] pio_out,
  output logic [CHANNELS*WIDTH-1:0] pio_oe,
  output logic                      irq
);

  localparam int NB = CHANNELS * WIDTH;
  // Width of the channel field. It is kept at least 1 bit so that a
  // single-channel build still has a legal signal.
  localparam int CW = (AW > 3) ? AW - 3 : 1;
  localparam logic [CW:0] CH_LIMIT = CHANNELS[CW:0];

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_MASK   = 3'd2;
  localparam logic [2:0] REG_CAP    = 3'd3;
  localparam logic [2:0] REG_OUTSET = 3'd4;
  localparam logic [2:0] REG_OUTCLR = 3'd5;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [CW-1:0]       ch_idx;
  logic [2:0]          reg_sel;
  logic                ch_ok;
  logic [CHANNELS-1:0] ch_hit;
  logic [NB-1:0]       wr_lane;   // all bits of the addressed channel
  logic [WIDTH-1:0]    wdata;
  logic [NB-1:0]       wdata_rep; // write data replicated to every channel
  logic [NB-1:0]       wr_bits;   // write data confined to addressed channel

  assign reg_sel = avs_address[2:0];

  generate
    if (AW > 3) begin : g_ch_field
      assign ch_idx = avs_address[AW-1:3];
    end else begin : g_ch_single
      assign ch_idx = '0;
    end
  endgenerate

  // Channel indices beyond CHANNELS select nothing.
  // They read 0 and their writes fall on an all-zero lane mask.
  assign ch_ok = ({1'b0, ch_idx} < CH_LIMIT);

  // One-hot channel select and the matching per-bit lane mask.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so that no path leaves it unassigned and infers a latch.
    ch_hit  = '0;
    wr_lane = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_hit[c]                  = ch_ok && (ch_idx == CW'(c));
      wr_lane[c*WIDTH +: WIDTH]  = {WIDTH{ch_hit[c]}};
    end
  end

  assign wdata     = avs_writedata[WIDTH-1:0];
  assign wdata_rep = {CHANNELS{wdata}};
  assign wr_bits   = wdata_rep & wr_lane;

  // Bits of avs_writedata above WIDTH are don't-care by definition.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // ---------------------------------------------------------------------
  // Output and direction registers (zero wait state writes)
  // ---------------------------------------------------------------------

  // Output register: plain load, atomic OR-set and AND-clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
      pio_out <= '0;
    end else if (avs_write) begin
      case (reg_sel)
        REG_DATA:   pio_out <= (pio_out & ~wr_lane) | wr_bits;
        REG_OUTSET: pio_out <= pio_out | wr_bits;
        REG_OUTCLR: pio_out <= pio_out & ~wr_bits;
        default:    pio_out <= pio_out;
      endcase
    end
  end

  // Direction register: 1 = drive the pad.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pio_oe <= '0;
    end else if (avs_write && (reg_sel == REG_DIR)) begin
      pio_oe <= (pio_oe & ~wr_lane) | wr_bits;
    end
  end

  // ---------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pio_in;
      s2 <= s1;
    end
  end

  // ---------------------------------------------------------------------
  // Edge capture and interrupt
  // ---------------------------------------------------------------------
  logic [NB-1:0] irq_mask;
  logic [NB-1:0] edge_cap;

`ifdef MP_PIO_BANK_IRQ_EN
  logic [NB-1:0] s3;
  logic [NB-1:0] edge_hit;
  logic [NB-1:0] cap_clr;
  logic [1:0]    prime_cnt;
  logic          primed;

  // History flop: the previous synchronised value, used to spot 0->1.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s3 <= '0;
    end else begin
      s3 <= s2;
    end
  end

  // Priming counter.
  // Edge detection stays blind for the first three cycles after reset.
  // During that time the synchroniser fills with pin levels that were
  // already high, which would otherwise look like rising edges.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      prime_cnt <= 2'd0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign primed   = (prime_cnt == 2'd3);
  // Driven bits never capture. Their pad value is our own output.
  assign edge_hit = s2 & ~s3 & ~pio_oe & {NB{primed}};
  assign cap_clr  = (avs_write && (reg_sel == REG_CAP)) ? wr_bits : '0;

  // Interrupt mask register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      irq_mask <= '0;
    end else if (avs_write && (reg_sel == REG_MASK)) begin
      irq_mask <= (irq_mask & ~wr_lane) | wr_bits;
    end
  end

  // Edge capture with write-1-to-clear.
  // The set term is ORed last, so a new edge beats a simultaneous clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
    end
  end

  // Registered level interrupt: any captured edge that is masked in.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end
`else
  assign irq_mask = '0;
  assign edge_cap = '0;
  assign irq      = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [NB-1:0]    data_view;
  logic [WIDTH-1:0] rd_word;

  // A DATA read shows the synchronised pad level on input bits.
  // On driven bits it shows the output register instead.
  assign data_view = (s2 & ~pio_oe) | (pio_out & pio_oe);

  // Register select for the addressed channel.
  // A missing channel or a reserved or write-only register yields 0.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_hit[c]) begin
        case (reg_sel)
          REG_DATA: rd_word = data_view[c*WIDTH +: WIDTH];
          REG_DIR:  rd_word = pio_oe[c*WIDTH +: WIDTH];
          REG_MASK: rd_word = irq_mask[c*WIDTH +: WIDTH];
          REG_CAP:  rd_word = edge_cap[c*WIDTH +: WIDTH];
          default:  rd_word = '0;
        endcase
      end
    end
  end

  // Registered read data with a one-cycle valid pulse.
  // Reads see pre-edge state, so a read that coincides with a write
  // returns the old value. Reset drops any pending valid.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= 32'(rd_word);
      end
    end
  end

endmodule

// File: tb/tb_mp_pio_bank.sv
// Testbench for mp_pio_bank (CHANNELS=3, WIDTH=8).
//
// The bench uses directed scenarios followed by randomized bus and pin
// traffic. It compares all outputs every cycle against a behavioural model,
// which holds one register set per channel plus a short pin-sample history.
// The bench also follows MP_PIO_BANK_IRQ_EN so that it matches the build
// under test.

module tb_mp_pio_bank;

  localparam int CHANNELS = 3;
  localparam int WIDTH    = 8;
  localparam int AW       = $clog2(CHANNELS) + 3;
  localparam int NB       = CHANNELS * WIDTH;

`ifdef MP_PIO_BANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic [NB-1:0] pio_in = '0;
  logic [NB-1:0] pio_out;
  logic [NB-1:0] pio_oe;
  logic          irq;

  mp_pio_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .pio_in            (pio_in),
    .pio_out           (pio_out),
    .pio_oe            (pio_oe),
    .irq               (irq)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] m_out  [CHANNELS];
  logic [WIDTH-1:0] m_oe   [CHANNELS];
  logic [WIDTH-1:0] m_mask [CHANNELS];
  logic [WIDTH-1:0] m_cap  [CHANNELS];
  // Pin samples at the most recent clock edges, oldest first.
  // hist[1] is the value visible to software; hist[0] is the one before it.
  logic [NB-1:0]    hist [$];
  int               m_cycles;   // edges since reset release, saturating at 3
  logic             m_irq;
  logic             m_rvalid;
  logic [31:0]      m_rdata;

  function automatic logic [NB-1:0] pack(input logic [WIDTH-1:0] v [CHANNELS]);
    logic [NB-1:0] r;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) r[c*WIDTH +: WIDTH] = v[c];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pin_slice(input logic [NB-1:0] v, input int c);
    return v[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    int ch;
    int rg;
    logic [WIDTH-1:0] pins;
    ch = addr / 8;
    rg = addr % 8;
    if (ch >= CHANNELS) return 32'h0;
    pins = pin_slice(hist[1], ch);
    case (rg)
      0: return 32'((pins & ~m_oe[ch]) | (m_out[ch] & m_oe[ch]));
      1: return 32'(m_oe[ch]);
      2: return IRQ_EN ? 32'(m_mask[ch]) : 32'h0;
      3: return IRQ_EN ? 32'(m_cap[ch]) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_out[c] = '0; m_oe[c] = '0; m_mask[c] = '0; m_cap[c] = '0;
    end
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('0);
    m_cycles = 0;
    m_irq    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  // Advance the model by one clock edge using the current bus and pin
  // inputs. Then let the DUT take the same edge and compare all outputs.
  task automatic step();
    logic [31:0]      rd_v;
    logic             any_irq;
    logic [WIDTH-1:0] edge_v [CHANNELS];
    logic [WIDTH-1:0] wd;
    int               ch;
    int               rg;
    if (reset_reset) begin
      model_reset();
    end else begin
      rd_v    = model_read(int'(avs_address));
      any_irq = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        any_irq   = any_irq | (|(m_cap[c] & m_mask[c]));
        edge_v[c] = (m_cycles >= 3)
                    ? (pin_slice(hist[1], c) & ~pin_slice(hist[0], c) & ~m_oe[c]) : '0;
      end
      wd = avs_writedata[WIDTH-1:0];
      ch = int'(avs_address) / 8;
      rg = int'(avs_address) % 8;
      if (avs_write && ch < CHANNELS) begin
        case (rg)
          0: m_out[ch] = wd;
          1: m_oe[ch]  = wd;
          2: if (IRQ_EN) m_mask[ch] = wd;
          3: if (IRQ_EN) m_cap[ch] = m_cap[ch] & ~wd;
          4: m_out[ch] = m_out[ch] | wd;
          5: m_out[ch] = m_out[ch] & ~wd;
          default: ;
        endcase
      end
      if (IRQ_EN) for (int c = 0; c < CHANNELS; c++) m_cap[c] = m_cap[c] | edge_v[c];
      m_irq    = IRQ_EN && any_irq;
      m_rvalid = avs_read;
      if (avs_read) m_rdata = rd_v;
      hist.push_back(pio_in);
      void'(hist.pop_front());
      if (m_cycles < 3) m_cycles++;
    end
    @(posedge clk_clk);
    #1;
    check("pio_out", 32'(pio_out), 32'(pack(m_out)));
    check("pio_oe", 32'(pio_oe), 32'(pack(m_oe)));
    check("irq", 32'(irq), 32'(m_irq));
    check("rvalid", 32'(avs_readdatavalid), 32'(m_rvalid));
    if (m_rvalid) check("rdata", avs_readdata, m_rdata);
  endtask

  task automatic idle();
    step();
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    avs_address   = AW'(a);
    avs_writedata = d;
    avs_write     = 1'b1;
    step();
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input int a);
    avs_address = AW'(a);
    avs_read    = 1'b1;
    step();
    avs_read    = 1'b0;
  endtask

  initial begin
    model_reset();

    // --- Reset with all pins high, then release ------------------------
    pio_in      = '1;
    reset_reset = 1'b1;
    repeat (3) step();
    reset_reset = 1'b0;
    check("rst_out", 32'(pio_out), 32'h0);
    check("rst_oe", 32'(pio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", avs_readdata, 32'h0);
    for (int i = 0; i < 10; i++) begin
      bus_read((i % CHANNELS) * 8 + 3);
      check("cap_after_rst", avs_readdata, 32'h0);
    end

    // --- Output set/clear on channel 1 ----------------------------------
    bus_write(8 + 1, 32'hFF);
    bus_write(8 + 0, 32'h0F);
    bus_write(8 + 4, 32'hC0);
    bus_write(8 + 5, 32'h03);
    bus_read(8 + 0);
    check("ch1_data", avs_readdata, 32'hCC);
    check("ch1_out", 32'(pio_out[15:8]), 32'hCC);
    check("ch0_out", 32'(pio_out[7:0]), 32'h00);
    check("ch2_out", 32'(pio_out[23:16]), 32'h00);

    // --- Edge capture and irq on ch0 bit 0 ------------------------------
    pio_in = '0;
    bus_write(1, 32'h00);
    bus_write(2, 32'h01);
    bus_write(3, 32'hFF);
    repeat (4) idle();
    check("irq_idle", 32'(irq), 32'h0);
    pio_in[0] = 1'b1;
    idle();            // edge k
    idle();            // k+1
    idle();            // k+2: capture set
    bus_read(3);       // k+3: irq rises, read returns capture
    check("cap_bit0", avs_readdata, IRQ_EN ? 32'h01 : 32'h00);
    check("irq_set", 32'(irq), 32'(IRQ_EN));
    bus_write(3, 32'h01);   // k+4: clear
    check("irq_hold", 32'(irq), 32'(IRQ_EN));
    idle();                 // k+5
    check("irq_clr", 32'(irq), 32'h0);

    // --- Set beats write-1-clear on ch0 bit 2 ---------------------------
    pio_in[2] = 1'b1;
    repeat (3) idle();
    pio_in[2] = 1'b0;
    repeat (4) idle();
    pio_in[2] = 1'b1;
    idle();                 // edge k
    idle();                 // k+1
    bus_write(3, 32'h04);   // k+2: clear collides with new edge
    bus_read(3);
    check("collide_bit2", avs_readdata & 32'h4, IRQ_EN ? 32'h4 : 32'h0);
    bus_write(3, 32'h04);
    bus_read(3);
    check("clear_bit2", avs_readdata & 32'h4, 32'h0);

    // --- Nonexistent channel and reserved register ----------------------
    bus_read(3 * 8 + 0);
    check("nochan_rd", avs_readdata, 32'h0);
    check("nochan_vld", 32'(avs_readdatavalid), 32'h1);
    bus_read(6);
    check("rsvd_rd", avs_readdata, 32'h0);
    check("rsvd_vld", 32'(avs_readdatavalid), 32'h1);
    for (int r = 0; r < 8; r++) bus_write(3 * 8 + r, 32'hFFFF_FFFF);
    bus_write(6, 32'hFFFF_FFFF);
    bus_write(7, 32'hFFFF_FFFF);
    for (int c = 0; c < CHANNELS; c++) begin
      bus_read(c * 8 + 1);
      bus_read(c * 8 + 2);
    end
    check("ghost_out", 32'(pio_out), 32'h00CC00);

    // --- Interrupt path with all masks open -----------------------------
    for (int c = 0; c < CHANNELS; c++) begin
      bus_write(c * 8 + 1, 32'h00);
      bus_write(c * 8 + 2, 32'hFF);
    end
    pio_in = '0;
    repeat (4) idle();
    pio_in = 24'hA5_5A_F0;
    repeat (4) idle();
    check("irq_all", 32'(irq), 32'(IRQ_EN));
    bus_read(2);
    check("mask_rd", avs_readdata, IRQ_EN ? 32'hFF : 32'h00);

    // --- Simultaneous read and write returns the old value --------------
    bus_write(16 + 0, 32'h3C);
    bus_write(16 + 1, 32'hFF);
    avs_read = 1'b1;
    bus_write(16 + 0, 32'h96);
    avs_read = 1'b0;
    check("rw_old", avs_readdata, 32'h3C);

    // --- Randomized traffic ----------------------------------------------
    for (int i = 0; i < 3000; i++) begin
      reset_reset   = ($urandom_range(0, 299) == 0);
      avs_address   = AW'($urandom_range(0, 31));
      avs_read      = $urandom_range(0, 1) == 1;
      avs_write     = $urandom_range(0, 9) < 4;
      avs_writedata = $urandom;
      if ($urandom_range(0, 2) == 0)
        pio_in = pio_in ^ NB'($urandom & $urandom & $urandom);
      step();
    end
    reset_reset = 1'b0;
    avs_read    = 1'b0;
    avs_write   = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
